// File: rtl/pipe_pkg.sv
// Pipeline payload types shared by the stage register bank.
//   ctrl_t      : decode-stage control bundle carried into E
//   fd_t..mw_t  : per-boundary register payloads
package pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RADR_W = 4;

  typedef struct packed {
    logic       RegWrite;
    logic       MemtoReg;
    logic       MemWrite;
    logic       Branch;
    logic       PCSrc;
    logic [1:0] ALUControl;
    logic [3:0] Cond;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
  } fd_t;

  typedef struct packed {
    logic              valid;
    ctrl_t             ctrl;
    logic [RADR_W-1:0] ra1;
    logic [RADR_W-1:0] ra2;
    logic [RADR_W-1:0] wa3;
    logic [XLEN-1:0]   src_a;
    logic [XLEN-1:0]   write_data;
    logic [XLEN-1:0]   ext_imm;
  } de_t;

  typedef struct packed {
    logic              reg_write;
    logic              memto_reg;
    logic              mem_write;
    logic              pc_src;
    logic [RADR_W-1:0] wa3;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   write_data;
  } em_t;

  typedef struct packed {
    logic              reg_write;
    logic              memto_reg;
    logic              pc_src;
    logic [RADR_W-1:0] wa3;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   read_data;
  } mw_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic stage register with async active-low reset; clr beats en.
//   clk, reset_n : clock / async reset
//   en           : load d when high
//   clr          : synchronous clear to zero (bubble), higher priority than en
//   d, q         : W-bit payload
module pipe_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (clr)  q <= '0;
    else if (en)   q <= d;
  end

endmodule

// File: rtl/pipe_stage_regs.sv
// F/D, D/E, E/M, M/W boundary registers of the 5-stage ARM core, with
// stall/flush handling, hazard feedback and saturating stall/flush counters.
//   Hazard controls : StallF, StallD, FlushD, FlushE
//   F->D            : InstrF/PCPlus4F -> InstrD/PCPlus4D/ValidD
//   D->E            : decode controls, register addresses, operands -> ...E
//   E->M            : gated controls + ALU result -> ...M
//   M->W            : controls + ALU result + load data -> ...W
//   PCWrPendingF    : a PC write is in flight in D, E or M
//   Stats           : StallCount, FlushCount, cleared by clear_stats
module pipe_stage_regs
  import pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              FlushE,
  input  logic [31:0]       InstrF,
  input  logic [31:0]       PCPlus4F,
  output logic [31:0]       InstrD,
  output logic [31:0]       PCPlus4D,
  output logic              ValidD,
  input  logic              RegWriteD,
  input  logic              MemtoRegD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              PCSrcD,
  input  logic [1:0]        ALUControlD,
  input  logic [3:0]        CondD,
  input  logic [3:0]        RA1D,
  input  logic [3:0]        RA2D,
  input  logic [3:0]        WA3D,
  input  logic [31:0]       SrcAD,
  input  logic [31:0]       WriteDataD,
  input  logic [31:0]       ExtImmD,
  output logic              RegWriteE,
  output logic              MemtoRegE,
  output logic              MemWriteE,
  output logic              BranchE,
  output logic              PCSrcE,
  output logic [1:0]        ALUControlE,
  output logic [3:0]        CondE,
  output logic [3:0]        RA1E,
  output logic [3:0]        RA2E,
  output logic [3:0]        WA3E,
  output logic [31:0]       SrcAE,
  output logic [31:0]       WriteDataE,
  output logic [31:0]       ExtImmE,
  output logic              ValidE,
  input  logic              RegWriteGE,
  input  logic              MemWriteGE,
  input  logic              PCSrcGE,
  input  logic [31:0]       ALUResultE,
  output logic              RegWriteM,
  output logic              MemtoRegM,
  output logic              MemWriteM,
  output logic              PCSrcM,
  output logic [3:0]        WA3M,
  output logic [31:0]       ALUResultM,
  output logic [31:0]       WriteDataM,
  input  logic [31:0]       ReadDataM,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic              PCSrcW,
  output logic [3:0]        WA3W,
  output logic [31:0]       ALUResultW,
  output logic [31:0]       ReadDataW,
  output logic              PCWrPendingF,
  input  logic              clear_stats,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  fd_t fd_d, fd_q;
  de_t de_d, de_q;
  em_t em_d, em_q;
  mw_t mw_d, mw_q;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Next-stage payload assembly
  always_comb begin
    fd_d          = '0;
    fd_d.valid    = 1'b1;
    fd_d.instr    = InstrF;
    fd_d.pc_plus4 = PCPlus4F;

    de_d                 = '0;
    de_d.valid           = fd_q.valid;
    de_d.ctrl.RegWrite   = RegWriteD;
    de_d.ctrl.MemtoReg   = MemtoRegD;
    de_d.ctrl.MemWrite   = MemWriteD;
    de_d.ctrl.Branch     = BranchD;
    de_d.ctrl.PCSrc      = PCSrcD;
    de_d.ctrl.ALUControl = ALUControlD;
    de_d.ctrl.Cond       = CondD;
    de_d.ra1             = RA1D;
    de_d.ra2             = RA2D;
    de_d.wa3             = WA3D;
    de_d.src_a           = SrcAD;
    de_d.write_data      = WriteDataD;
    de_d.ext_imm         = ExtImmD;

    em_d            = '0;
    em_d.reg_write  = RegWriteGE;
    em_d.memto_reg  = de_q.ctrl.MemtoReg;
    em_d.mem_write  = MemWriteGE;
    em_d.pc_src     = PCSrcGE;
    em_d.wa3        = de_q.wa3;
    em_d.alu_result = ALUResultE;
    em_d.write_data = de_q.write_data;

    mw_d            = '0;
    mw_d.reg_write  = em_q.reg_write;
    mw_d.memto_reg  = em_q.memto_reg;
    mw_d.pc_src     = em_q.pc_src;
    mw_d.wa3        = em_q.wa3;
    mw_d.alu_result = em_q.alu_result;
    mw_d.read_data  = ReadDataM;
  end

  // F/D: flush wins over stall (taken branch during a load-use stall)
  pipe_reg #(.W($bits(fd_t))) u_fd (
    .clk(clk), .reset_n(reset_n), .en(~StallD), .clr(FlushD), .d(fd_d), .q(fd_q)
  );

  // D/E: no stall; a flush inserts a bubble
  pipe_reg #(.W($bits(de_t))) u_de (
    .clk(clk), .reset_n(reset_n), .en(1'b1), .clr(FlushE), .d(de_d), .q(de_q)
  );

  pipe_reg #(.W($bits(em_t))) u_em (
    .clk(clk), .reset_n(reset_n), .en(1'b1), .clr(1'b0), .d(em_d), .q(em_q)
  );

  pipe_reg #(.W($bits(mw_t))) u_mw (
    .clk(clk), .reset_n(reset_n), .en(1'b1), .clr(1'b0), .d(mw_d), .q(mw_q)
  );

  // Saturating event counters; clear beats increment
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (clear_stats) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (FlushE && (flush_cnt_q != CNT_MAX)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign InstrD   = fd_q.instr;
  assign PCPlus4D = fd_q.pc_plus4;
  assign ValidD   = fd_q.valid;

  assign RegWriteE   = de_q.ctrl.RegWrite;
  assign MemtoRegE   = de_q.ctrl.MemtoReg;
  assign MemWriteE   = de_q.ctrl.MemWrite;
  assign BranchE     = de_q.ctrl.Branch;
  assign PCSrcE      = de_q.ctrl.PCSrc;
  assign ALUControlE = de_q.ctrl.ALUControl;
  assign CondE       = de_q.ctrl.Cond;
  assign RA1E        = de_q.ra1;
  assign RA2E        = de_q.ra2;
  assign WA3E        = de_q.wa3;
  assign SrcAE       = de_q.src_a;
  assign WriteDataE  = de_q.write_data;
  assign ExtImmE     = de_q.ext_imm;
  assign ValidE      = de_q.valid;

  assign RegWriteM  = em_q.reg_write;
  assign MemtoRegM  = em_q.memto_reg;
  assign MemWriteM  = em_q.mem_write;
  assign PCSrcM     = em_q.pc_src;
  assign WA3M       = em_q.wa3;
  assign ALUResultM = em_q.alu_result;
  assign WriteDataM = em_q.write_data;

  assign RegWriteW  = mw_q.reg_write;
  assign MemtoRegW  = mw_q.memto_reg;
  assign PCSrcW     = mw_q.pc_src;
  assign WA3W       = mw_q.wa3;
  assign ALUResultW = mw_q.alu_result;
  assign ReadDataW  = mw_q.read_data;

  // Gated by reset_n so the output reads 0 while reset is held, even if PCSrcD is high
  assign PCWrPendingF = reset_n & (PCSrcD | de_q.ctrl.PCSrc | em_q.pc_src);

  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
module tb_pipe_stage_regs;

  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic reset_n;
  logic StallF, StallD, FlushD, FlushE;
  logic [31:0] InstrF, PCPlus4F, InstrD, PCPlus4D;
  logic ValidD;
  logic RegWriteD, MemtoRegD, MemWriteD, BranchD, PCSrcD;
  logic [1:0] ALUControlD, ALUControlE;
  logic [3:0] CondD, CondE, RA1D, RA2D, WA3D, RA1E, RA2E, WA3E;
  logic [31:0] SrcAD, WriteDataD, ExtImmD, SrcAE, WriteDataE, ExtImmE;
  logic RegWriteE, MemtoRegE, MemWriteE, BranchE, PCSrcE, ValidE;
  logic RegWriteGE, MemWriteGE, PCSrcGE;
  logic [31:0] ALUResultE;
  logic RegWriteM, MemtoRegM, MemWriteM, PCSrcM;
  logic [3:0] WA3M, WA3W;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM, ALUResultW, ReadDataW;
  logic RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF, clear_stats;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_regs #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .InstrF(InstrF), .PCPlus4F(PCPlus4F),
    .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .MemWriteD(MemWriteD),
    .BranchD(BranchD), .PCSrcD(PCSrcD), .ALUControlD(ALUControlD), .CondD(CondD),
    .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
    .SrcAD(SrcAD), .WriteDataD(WriteDataD), .ExtImmD(ExtImmD),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .PCSrcE(PCSrcE), .ALUControlE(ALUControlE), .CondE(CondE),
    .RA1E(RA1E), .RA2E(RA2E), .WA3E(WA3E),
    .SrcAE(SrcAE), .WriteDataE(WriteDataE), .ExtImmE(ExtImmE), .ValidE(ValidE),
    .RegWriteGE(RegWriteGE), .MemWriteGE(MemWriteGE), .PCSrcGE(PCSrcGE),
    .ALUResultE(ALUResultE),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .PCSrcM(PCSrcM), .WA3M(WA3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW), .WA3W(WA3W),
    .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
    .PCWrPendingF(PCWrPendingF), .clear_stats(clear_stats),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    {StallF, StallD, FlushD, FlushE} = '0;
    InstrF = '0; PCPlus4F = '0;
    {RegWriteD, MemtoRegD, MemWriteD, BranchD, PCSrcD} = '0;
    ALUControlD = '0; CondD = '0; RA1D = '0; RA2D = '0; WA3D = '0;
    SrcAD = '0; WriteDataD = '0; ExtImmD = '0;
    {RegWriteGE, MemWriteGE, PCSrcGE} = '0;
    ALUResultE = '0; ReadDataM = '0; clear_stats = 1'b0;

    // Reset state
    step(); step();
    chk("rst_instrD", InstrD, 32'h0);
    chk("rst_validD", 32'(ValidD), 32'd0);
    chk("rst_validE", 32'(ValidE), 32'd0);
    chk("rst_stallcnt", 32'(StallCount), 32'd0);
    chk("rst_pending", 32'(PCWrPendingF), 32'd0);
    reset_n = 1'b1;

    // Load three instructions
    InstrF = 32'h1111_1111; PCPlus4F = 32'd4;
    step();
    chk("ld1_instrD", InstrD, 32'h1111_1111);
    chk("ld1_validD", 32'(ValidD), 32'd1);
    chk("ld1_validE", 32'(ValidE), 32'd0);
    InstrF = 32'h2222_2222; PCPlus4F = 32'd8;
    step();
    InstrF = 32'h3333_3333; PCPlus4F = 32'd12;
    step();
    chk("ld3_instrD", InstrD, 32'h3333_3333);
    chk("ld3_pc4D", PCPlus4D, 32'd12);
    chk("ld3_validE", 32'(ValidE), 32'd1);

    // Reset mid-stream: outputs clear without waiting for an edge
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_instrD", InstrD, 32'h0);
    chk("midrst_validD", 32'(ValidD), 32'd0);
    chk("midrst_validE", 32'(ValidE), 32'd0);
    reset_n = 1'b1;
    InstrF = 32'h4444_4444; PCPlus4F = 32'd16;
    step();
    chk("postrst_instrD", InstrD, 32'h4444_4444);

    // Load-use stall: hold D, bubble E
    InstrF = 32'hE591_2000; RegWriteD = 1'b1;
    StallF = 1'b1; StallD = 1'b1; FlushE = 1'b1;
    step();
    chk("lu_instrD", InstrD, 32'h4444_4444);
    chk("lu_regwriteE", 32'(RegWriteE), 32'd0);
    chk("lu_validE", 32'(ValidE), 32'd0);
    chk("lu_stallcnt", 32'(StallCount), 32'd1);
    chk("lu_flushcnt", 32'(FlushCount), 32'd1);
    StallF = 1'b0; StallD = 1'b0; FlushE = 1'b0;
    step();
    chk("lu2_instrD", InstrD, 32'hE591_2000);
    chk("lu2_regwriteE", 32'(RegWriteE), 32'd1);
    chk("lu2_validE", 32'(ValidE), 32'd1);

    // Branch during stall: flush beats stall
    StallD = 1'b1; FlushD = 1'b1; FlushE = 1'b1;
    step();
    chk("br_instrD", InstrD, 32'h0);
    chk("br_validD", 32'(ValidD), 32'd0);
    chk("br_validE", 32'(ValidE), 32'd0);
    chk("br_regwriteE", 32'(RegWriteE), 32'd0);
    chk("br_flushcnt", 32'(FlushCount), 32'd2);
    StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;

    // Writeback path
    WA3D = 4'd5; RegWriteD = 1'b1; RegWriteGE = 1'b1;
    SrcAD = 32'h1234_5678; CondD = 4'hE; ALUControlD = 2'b10; RA1D = 4'd3;
    step();
    chk("wb_wa3E", 32'(WA3E), 32'd5);
    chk("wb_srcaE", SrcAE, 32'h1234_5678);
    chk("wb_condE", 32'(CondE), 32'hE);
    chk("wb_aluctlE", 32'(ALUControlE), 32'd2);
    chk("wb_ra1E", 32'(RA1E), 32'd3);
    WA3D = 4'd0; RegWriteD = 1'b0; ALUResultE = 32'hDEAD_BEEF;
    step();
    chk("wb_wa3M", 32'(WA3M), 32'd5);
    chk("wb_regwriteM", 32'(RegWriteM), 32'd1);
    chk("wb_aluM", ALUResultM, 32'hDEAD_BEEF);
    ReadDataM = 32'hCAFE_F00D; ALUResultE = 32'h0;
    step();
    chk("wb_wa3W", 32'(WA3W), 32'd5);
    chk("wb_regwriteW", 32'(RegWriteW), 32'd1);
    chk("wb_aluW", ALUResultW, 32'hDEAD_BEEF);
    chk("wb_rdW", ReadDataW, 32'hCAFE_F00D);
    RegWriteGE = 1'b0;
    step();
    chk("wb_gated_regwriteM", 32'(RegWriteM), 32'd0);
    step();

    // PCSrc tracking
    chk("pc_idle", 32'(PCWrPendingF), 32'd0);
    PCSrcD = 1'b1;
    #1;
    chk("pc_pendD", 32'(PCWrPendingF), 32'd1);
    step();
    PCSrcD = 1'b0; PCSrcGE = 1'b1;
    #1;
    chk("pc_pendE", 32'(PCWrPendingF), 32'd1);
    step();
    PCSrcGE = 1'b0;
    #1;
    chk("pc_pendM", 32'(PCWrPendingF), 32'd1);
    chk("pc_srcW_pre", 32'(PCSrcW), 32'd0);
    step();
    chk("pc_pend_done", 32'(PCWrPendingF), 32'd0);
    chk("pc_srcW", 32'(PCSrcW), 32'd1);
    step();
    chk("pc_srcW_end", 32'(PCSrcW), 32'd0);

    // Saturation with a held D-stall; InstrD must stay put
    InstrF = 32'h5555_5555;
    step();
    chk("sat_pre_instrD", InstrD, 32'h5555_5555);
    StallF = 1'b1; StallD = 1'b1;
    for (int i = 0; i < 20; i++) begin
      InstrF = 32'h6000_0000 + 32'(i);
      step();
    end
    chk("sat_instrD", InstrD, 32'h5555_5555);
    chk("sat_stallcnt", 32'(StallCount), 32'd15);
    clear_stats = 1'b1;
    step();
    chk("clr_stallcnt", 32'(StallCount), 32'd0);
    chk("clr_flushcnt", 32'(FlushCount), 32'd0);
    clear_stats = 1'b0;
    step();
    chk("post_clr_stallcnt", 32'(StallCount), 32'd1);
    StallF = 1'b0; StallD = 1'b0;
    step();
    chk("post_stall_instrD", InstrD, 32'h6000_0013);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
